// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction-fetch master:
//   - fetch_state_t : controller states
//   - AXI_*         : fixed read-address channel attributes (single 8-byte beat)
//   - fetch_pair_t  : one buffered instruction pair as handed to decode
//   - align_pair()  : rounds an address down to its 8-byte pair boundary
// ----------------------------------------------------------------------------
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_DROP
    } fetch_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [7:0] AXI_LEN_1      = 8'd0;   // arlen encodes beats-1

    typedef struct packed {
        logic [31:0] pc;      // 8-aligned address of the pair
        logic [63:0] instr;   // [31:0] = instr at pc, [63:32] = instr at pc+4
        logic [1:0]  mask;    // bit0 = low instr valid, bit1 = high instr valid
    } fetch_pair_t;

    function automatic logic [31:0] align_pair(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ----------------------------------------------------------------------------
// ifetch_fifo
// Synchronous FIFO with a registered head word. A word pushed into an empty
// FIFO is visible on o_head the following cycle. Flush empties the FIFO in
// one cycle and takes priority over push and pop.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push/i_push_data write one word (caller never pushes when full)
//   i_pop             remove the head word (ignored when empty)
//   i_flush           discard all contents
//   o_full, o_empty   occupancy flags
//   o_count           number of stored words (0..DEPTH)
//   o_head            current head word, valid while !o_empty
// ----------------------------------------------------------------------------
module ifetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4    // power of two, >= 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [WIDTH-1:0]       o_head
);
    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [PW-1:0]    w_rd_ptr_nxt;
    logic [PW:0]      w_remain;     // entries left after this cycle's pop

    assign w_pop_ok     = i_pop && (r_count != '0);
    assign w_push_ok    = i_push && (r_count != FULL_CNT);
    // Pointers are PW bits wide, so wrap modulo DEPTH comes for free.
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop_ok);
    assign w_remain     = r_count - (PW + 1)'(w_pop_ok);

    // NOTE: storage has no reset; a slot is only read after it was written,
    // and the reset-visible head value lives in r_head.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= r_wr_ptr + PW'(w_push_ok);
            r_count  <= w_remain + (PW + 1)'(w_push_ok);
            // Head is preloaded so it is a plain register at the output:
            // a push into an (effectively) empty FIFO bypasses storage.
            if (w_push_ok && (w_remain == '0)) begin
                r_head <= i_push_data;
            end else if (w_pop_ok && (w_remain != '0)) begin
                r_head <= r_mem[w_rd_ptr_nxt];
            end
        end
    end

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_head;

endmodule

// File: rtl/ifetch_master.sv
// ----------------------------------------------------------------------------
// ifetch_master
// Instruction-fetch master: issues single-beat 8-byte reads to the
// instruction cache, buffers returned instruction pairs in a FIFO and
// presents them to decode. Branch/exception redirects flush the buffer and
// restart fetch; a read already in flight is completed and its data dropped.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   arvalid/araddr/arburst/arsize/arlen read-address channel (out)
//   arready                             read-address accept (in)
//   rvalid/rdata/rlast, rready          read-data channel
//   redirect_valid/redirect_pc          fetch restart request
//   dec_valid/dec_pc/dec_instr/dec_mask head pair to decode
//   dec_ready                           decode consumes the head pair
// ----------------------------------------------------------------------------
module ifetch_master
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,   // 8-byte aligned
    parameter int          DEPTH    = 4                // power of two, 2..16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [1:0]  arburst,
    output logic [2:0]  arsize,
    output logic [7:0]  arlen,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [63:0] rdata,
    input  logic        rlast,
    output logic        rready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [63:0] dec_instr,
    output logic [1:0]  dec_mask,
    input  logic        dec_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_araddr;
    logic [1:0]   r_cur_mask;
    logic         r_arvalid;
    logic         r_rready;
    logic         r_kill;       // redirect seen while AR still waiting for arready

    logic [31:0]  w_redir_pc;
    logic [31:0]  w_next_pc;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic [CW-1:0] w_count;
    logic         w_room_after_push;
    fetch_pair_t  w_push_pair;
    fetch_pair_t  w_head;
    logic         w_unused;

    // Every beat is a complete single-beat transfer, so rlast carries no
    // information; the low address bits of a redirect are ignored.
    assign w_unused = ^{rlast, redirect_pc[1:0]};

    assign w_redir_pc = align_pair(redirect_pc);
    assign w_next_pc  = redirect_valid ? w_redir_pc : r_fetch_pc;
    assign w_push     = (r_state == ST_WAIT_R) && rvalid && !redirect_valid;
    assign w_pop      = dec_valid && dec_ready;
    assign w_room_after_push =
        (w_count + CW'(1) - CW'(w_pop)) < CW'(DEPTH);

    assign w_push_pair = '{pc: r_araddr, instr: rdata, mask: r_cur_mask};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_araddr   <= RESET_PC;
            r_cur_mask <= 2'b11;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
                // Entering mid-pair: only the high instruction is wanted.
                r_cur_mask <= redirect_pc[2] ? 2'b10 : 2'b11;
            end else if (w_push) begin
                r_cur_mask <= 2'b11;
            end

            case (r_state)
                ST_IDLE: begin
                    if (redirect_valid || !w_full) begin
                        r_state   <= ST_REQ;
                        r_arvalid <= 1'b1;
                        r_araddr  <= w_next_pc;
                    end
                end
                ST_REQ: begin
                    // AR stays frozen until accepted even across a redirect;
                    // the data it returns is then discarded in DROP.
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_kill    <= 1'b0;
                        if (redirect_valid || r_kill) begin
                            r_state <= ST_DROP;
                        end else begin
                            r_state    <= ST_WAIT_R;
                            r_fetch_pc <= r_fetch_pc + 32'd8;
                        end
                    end else if (redirect_valid) begin
                        r_kill <= 1'b1;
                    end
                end
                ST_WAIT_R: begin
                    if (rvalid) begin
                        r_rready <= 1'b0;
                        if (redirect_valid || w_room_after_push) begin
                            r_state   <= ST_REQ;
                            r_arvalid <= 1'b1;
                            r_araddr  <= w_next_pc;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (redirect_valid) begin
                        r_state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (rvalid) begin
                        r_rready  <= 1'b0;
                        r_state   <= ST_REQ;
                        r_arvalid <= 1'b1;
                        r_araddr  <= w_next_pc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ifetch_fifo #(
        .WIDTH ($bits(fetch_pair_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_pair),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign arvalid   = r_arvalid;
    assign araddr    = r_araddr;
    assign arburst   = AXI_BURST_INCR;
    assign arsize    = AXI_SIZE_8B;
    assign arlen     = AXI_LEN_1;
    assign rready    = r_rready;
    assign dec_valid = !w_empty;
    assign dec_pc    = w_head.pc;
    assign dec_instr = w_head.instr;
    assign dec_mask  = w_head.mask;

endmodule
